// File: rtl/ssc_pkg.sv
// Shared constants and types for the ADC capture buffer: register map,
// CTRL/STATUS field positions and the stored sample word layout.
package ssc_pkg;

    localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] DATA_OFS   = 32'h0000_0008;
    localparam logic [31:0] THRESH_OFS = 32'h0000_000C;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_DEC_EN_BIT = 1;
    localparam int CTRL_DEC_M_LSB  = 8;
    localparam int CTRL_DEC_M_MSB  = 11;

    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_OVF_BIT   = 18;
    localparam int STAT_THR_BIT   = 19;

    typedef struct packed {
        logic        valid;
        logic [6:0]  channel;
        logic [23:0] sample;
    } sample_word_t;

    function automatic sample_word_t make_word(input logic [6:0] ch, input logic [23:0] smp);
        sample_word_t w;
        w.valid   = 1'b1;
        w.channel = ch;
        w.sample  = smp;
        return w;
    endfunction

endpackage

// File: rtl/ssc_sync_fifo.sv
// Single-clock FIFO. A pop on empty is ignored; a push on full is accepted
// only when a pop frees a slot in the same cycle.
module ssc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == (AW+1)'(DEPTH));
    assign empty  = (count_r == '0);
    assign count  = count_r;
    assign rdata  = mem_r[rd_ptr_r];
    assign pop_s  = pop & ~empty;
    assign push_s = push & (~full | pop_s);

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/ssc_adc_buffer.sv
// ADC capture buffer: channel tagging, frame decimation, FIFO storage and
// a small register block for host draining and threshold interrupt.
module ssc_adc_buffer
    import ssc_pkg::*;
#(
    parameter int          ADC_W  = 16,
    parameter int          NUM_CH = 4,
    parameter int          DEPTH  = 64,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      Wdata,
    input  logic             write,
    output logic [31:0]      Rdata,
    input  logic             read,
    input  logic [ADC_W-1:0] ADC,
    input  logic             pushADC,
    output logic             irq
);
    localparam int AW = $clog2(DEPTH);

    logic        en_r, dec_en_r;
    logic [3:0]  dec_m_r, dec_m_act_r, fr_r;
    logic [15:0] thresh_r;
    logic        ovf_r;
    logic [6:0]  ch_r;

    logic [31:0] ofs_s;
    logic        wr_ctrl_s, wr_status_s, wr_thresh_s, pop_req_s;
    logic        accept_s, store_s, clear_s, ch_wrap_s, fr_wrap_s;
    logic        full_s, empty_s, thr_hit_s;
    logic [AW:0] count_s;
    logic [15:0] count16_s;
    logic [31:0] fifo_rdata_s;
    sample_word_t word_s;
    logic        unused_wdata_s;

    assign ofs_s       = addr - BASE;
    assign wr_ctrl_s   = write & (ofs_s == CTRL_OFS);
    assign wr_status_s = write & (ofs_s == STATUS_OFS);
    assign wr_thresh_s = write & (ofs_s == THRESH_OFS);
    assign pop_req_s   = read  & (ofs_s == DATA_OFS);

    assign accept_s  = pushADC & en_r;
    assign clear_s   = wr_ctrl_s & ~Wdata[CTRL_EN_BIT];
    assign ch_wrap_s = accept_s & (ch_r >= 7'(NUM_CH-1));
    assign fr_wrap_s = ch_wrap_s & (fr_r >= dec_m_act_r);
    assign store_s   = accept_s & (~dec_en_r | (fr_r == 4'd0));
    assign word_s    = make_word(ch_r, 24'(ADC));

    assign count16_s      = 16'(count_s);
    assign thr_hit_s      = (thresh_r != 16'd0) && (count16_s >= thresh_r);
    assign irq            = thr_hit_s | ovf_r;
    assign unused_wdata_s = ^Wdata;

    ssc_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (store_s),
        .wdata (word_s),
        .pop   (pop_req_s),
        .rdata (fifo_rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Control/threshold registers and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r     <= 1'b0;
            dec_en_r <= 1'b0;
            dec_m_r  <= 4'd0;
            thresh_r <= 16'(DEPTH/2);
            ovf_r    <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                en_r     <= Wdata[CTRL_EN_BIT];
                dec_en_r <= Wdata[CTRL_DEC_EN_BIT];
                dec_m_r  <= Wdata[CTRL_DEC_M_MSB:CTRL_DEC_M_LSB];
            end
            if (wr_thresh_s) thresh_r <= Wdata[15:0];
            // A new overflow in the same cycle as a clear wins
            if (store_s && full_s && !pop_req_s)         ovf_r <= 1'b1;
            else if (wr_status_s && Wdata[STAT_OVF_BIT]) ovf_r <= 1'b0;
            else                                         ovf_r <= ovf_r;
        end
    end

    // Channel and frame counters; the active frame length only reloads at a wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_r        <= 7'd0;
            fr_r        <= 4'd0;
            dec_m_act_r <= 4'd0;
        end else begin
            if (clear_s) begin
                ch_r <= 7'd0;
                fr_r <= 4'd0;
            end else if (accept_s) begin
                ch_r <= ch_wrap_s ? 7'd0 : ch_r + 7'd1;
                if (fr_wrap_s)      fr_r <= 4'd0;
                else if (ch_wrap_s) fr_r <= fr_r + 4'd1;
                else                fr_r <= fr_r;
            end
            if (!en_r)          dec_m_act_r <= wr_ctrl_s ? Wdata[CTRL_DEC_M_MSB:CTRL_DEC_M_LSB] : dec_m_r;
            else if (fr_wrap_s) dec_m_act_r <= dec_m_r;
            else                dec_m_act_r <= dec_m_act_r;
        end
    end

    // Bus read mux; an empty DATA read returns an invalid (all-zero) word
    always_comb begin
        Rdata = 32'd0;
        if (read) begin
            case (ofs_s)
                CTRL_OFS:   Rdata = {20'd0, dec_m_r, 6'd0, dec_en_r, en_r};
                STATUS_OFS: Rdata = {12'd0, thr_hit_s, ovf_r, full_s, empty_s, count16_s};
                DATA_OFS:   Rdata = empty_s ? 32'd0 : fifo_rdata_s;
                THRESH_OFS: Rdata = {16'd0, thresh_r};
                default:    Rdata = 32'd0;
            endcase
        end else begin
            Rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_ssc_adc_buffer.sv
// Directed self-checking bench for ssc_adc_buffer with default parameters
// (ADC_W=16, NUM_CH=4, DEPTH=64, BASE=0).
module tb_ssc_adc_buffer;

    logic        clk, rst;
    logic [31:0] addr, Wdata, Rdata;
    logic        write, read, pushADC, irq;
    logic [15:0] ADC;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_rdata;
    logic        last_irq;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        rd;
        logic        push;
        logic [15:0] adc;
        logic        chk;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    ssc_adc_buffer #(.ADC_W(16), .NUM_CH(4), .DEPTH(64), .BASE(32'h0)) dut (
        .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
        .Rdata(Rdata), .read(read), .ADC(ADC), .pushADC(pushADC), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic r,
                       input logic p, input logic [15:0] d, input logic c, input logic [31:0] e);
        vecs[nvec] = '{a, w, wd, r, p, d, c, e, 1'b0};
        nvec++;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic r, input logic p, input logic [15:0] d);
        addr = a; write = w; Wdata = wd; read = r; pushADC = p; ADC = d;
    endtask

    // One bus cycle: drive at negedge, sample mid-low-phase, return at next negedge
    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic r, input logic p, input logic [15:0] d);
        drive(a, w, wd, r, p, d);
        #2;
        last_rdata = Rdata;
        last_irq   = irq;
        @(negedge clk);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic rd_status(input string nm, input logic [31:0] exp);
        cyc(32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
        check(nm, last_rdata, exp);
    endtask

    initial begin
        logic [31:0] exp_w;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset readback, basic channel tagging and empty read
        add(32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0000_0000);
        add(32'h4,  1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0001_0000);
        add(32'h8,  1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0000_0000);
        add(32'hC,  1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0000_0020);
        add(32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0000_0000);
        add(32'h0,  1'b1, 32'h1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++)
            add(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'(16'h100 + i), 1'b0, 32'h0);
        add(32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0000_0008);
        for (int i = 0; i < 8; i++)
            add(32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1,
                {1'b1, 7'(i % 4), 24'(32'h100 + i)});
        add(32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0000_0000);
        add(32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0001_0000);

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].push, vecs[i].adc);
            #2;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rdata", i), Rdata, vecs[i].exp_rdata);
                check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            end
            @(negedge clk);
        end
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);

        // Decimation: keep 1 frame of every 3
        cyc(32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        cyc(32'h0, 1'b1, 32'h203, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 24; i++) cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'(16'h300 + i));
        rd_status("dec_count", 32'h0000_0008);
        for (int i = 0; i < 8; i++) begin
            cyc(32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
            exp_w = {1'b1, 7'(i % 4), 24'((i < 4) ? (32'h300 + i) : (32'h30C + i - 4))};
            check($sformatf("dec_word%0d", i), last_rdata, exp_w);
        end

        // Overflow, sticky clear, push+pop on full
        cyc(32'h0, 1'b1, 32'h1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 66; i++) cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'(16'h200 + i));
        rd_status("ovf_status", 32'h000E_0040);
        check("ovf_irq", {31'd0, irq}, 32'd1);
        cyc(32'h4, 1'b1, 32'h0004_0000, 1'b0, 1'b0, 16'h0);
        rd_status("ovf_cleared", 32'h000A_0040);
        cyc(32'h8, 1'b0, 32'h0, 1'b1, 1'b1, 16'h2FF);
        check("full_pushpop_word", last_rdata, 32'h8000_0200);
        rd_status("full_pushpop_count", 32'h000A_0040);
        for (int i = 0; i < 64; i++) begin
            cyc(32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
            if (i == 0)  check("drain_first", last_rdata, 32'h8100_0201);
            if (i == 63) check("drain_last",  last_rdata, 32'h8200_02FF);
        end
        rd_status("drained", 32'h0001_0000);

        // Threshold interrupt timing
        cyc(32'hC, 1'b1, 32'h3, 1'b0, 1'b0, 16'h0);
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'h400);
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'h401);
        #1 check("thr_irq_low", {31'd0, irq}, 32'd0);
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'h402);
        #1 check("thr_irq_rise", {31'd0, irq}, 32'd1);
        cyc(32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
        check("thr_read_word", last_rdata, 32'h8300_0400);
        check("thr_irq_during_read", {31'd0, last_irq}, 32'd1);
        #1 check("thr_irq_fall", {31'd0, irq}, 32'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'(16'h500 + i));
        rd_status("pre_rst_count", 32'h0008_0005);
        drive(32'h4, 1'b0, 32'h0, 1'b1, 1'b1, 16'h77);
        #3 rst = 1'b1;
        #1 check("rst_status", Rdata, 32'h0001_0000);
        addr = 32'h0;
        #1 check("rst_ctrl", Rdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        rst = 1'b0;
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'h66);
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'h67);
        rd_status("push_ignored_en0", 32'h0001_0000);
        cyc(32'h0, 1'b1, 32'h1, 1'b0, 1'b0, 16'h0);
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 16'h55);
        cyc(32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
        check("post_rst_word", last_rdata, 32'h8000_0055);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssc_adc_buffer.md
# ssc_adc_buffer

Parametrised ADC capture buffer for the spread-spectrum analyzer datapath. It accepts the serial `ADC`/`pushADC` sample stream, tags each sample with its channel index in round-robin order, and optionally decimates by whole frames. Samples are stored in a FIFO, and the host drains them over the existing `addr`/`Wdata`/`write`/`Rdata`/`read` register bus. It replaces fixed single-channel capture with configurable width, depth, channel count and a threshold interrupt.

## Interface
- `ADC_W`, 16: sample width; legal range 1..24.
- `NUM_CH`, 4: channels interleaved in the stream; legal range 1..128.
- `DEPTH`, 64: FIFO entries; must be a power of two, at least 2.
- `BASE`, 32'h0: base address of the register block.
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `addr` input, 32 bits: bus address.
- `Wdata` input, 32 bits: bus write data.
- `write` input, 1 bit: write strobe, sampled for one cycle.
- `Rdata` output, 32 bits: bus read data.
- `read` input, 1 bit: read strobe, sampled for one cycle.
- `ADC` input, `ADC_W` bits: sample.
- `pushADC` input, 1 bit: `ADC` is valid this cycle.
- `irq` output, 1 bit: level interrupt.

## Operation
- Registers, offsets from `BASE`:
  - `0x00 CTRL` (RW): bit0 EN, bit1 DEC_EN, bits[11:8] DEC_M (keep 1 frame of every DEC_M+1). Reset value 0.
  - `0x04 STATUS`: bits[15:0] COUNT (RO), bit16 EMPTY (RO), bit17 FULL (RO), bit18 OVF (sticky; write 1 to clear), bit19 THR_HIT (RO).
  - `0x08 DATA` (RO): a read pops one FIFO entry.
  - `0x0C THRESH` (RW, bits[15:0]): reset value `DEPTH/2`.
  - Any other offset reads 0; writes to it are ignored.
- Stored word format: bit31 VALID=1, bits[30:24] channel index, bits[23:0] sample zero-extended from `ADC_W`.
- Reading DATA while the FIFO is empty returns 0 (VALID=0) and leaves all state unchanged.
- Channel counter (`ch`):
  - Advances on every `pushADC` while EN=1, wrapping `NUM_CH-1` -> 0.
  - Cleared on reset and on any CTRL write that sets EN=0.
  - `pushADC` while EN=0 is ignored; neither counter advances.
- Frame counter (`fr`):
  - Advances when `ch` wraps; wraps DEC_M -> 0.
  - A sample is stored only when DEC_EN=0, or when DEC_EN=1 and `fr`=0.
  - Cleared together with `ch`. Changing DEC_M while EN=1 takes effect at the next wrap of `fr`.
- FIFO:
  - A store while FULL drops the sample, sets OVF, and still advances `ch`/`fr`.
  - Simultaneous store and pop when FULL: both happen and COUNT stays the same.
  - Simultaneous store and pop when EMPTY: the pop returns VALID=0 and the store succeeds.
- Interrupt: `irq = THR_HIT | OVF`, where THR_HIT = (COUNT >= THRESH) and THRESH != 0.

## Timing
- `Rdata` is combinational from `addr` and the current state while `read`=1, and 0 while `read`=0.
- A DATA pop takes effect at the rising edge that ends the read cycle; the next read sees the next entry.
- Write latency: a register write takes effect at the edge that ends the write cycle.
- Sample latency: a sample pushed in cycle N is visible in COUNT, and readable via DATA, from cycle N+1.
- `read` and `write` asserted in the same cycle: both are performed.
- Reset values:
  - `Rdata`=0 and `irq`=0.
  - FIFO empty (COUNT=0, EMPTY=1), OVF=0.
  - CTRL=0 and THRESH=`DEPTH/2`.
- Reset asserted mid-operation: FIFO contents are discarded immediately; no partial pop or push completes.
- COUNT is `$clog2(DEPTH)+1` bits wide, zero-extended to 16 bits. Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Structure
- Package `ssc_pkg` holds:
  - Register offset constants `CTRL_OFS`, `STATUS_OFS`, `DATA_OFS`, `THRESH_OFS`.
  - Bit-position constants for the CTRL and STATUS fields.
  - The packed `sample_word_t` type (valid, channel, sample).
- One sub-module, `ssc_sync_fifo`: parametrised width and depth, push/pop/full/empty/count, with the same-cycle push/pop rules above.
- The top level contains the register decode, the channel and frame counters, the decimation gate, and the irq logic.

## Test plan
- Reset, then read all four registers -> CTRL=0, STATUS=0x0001_0000, DATA=0, THRESH=`DEPTH/2`; `irq`=0.
- `NUM_CH`=4, EN=1; push 8 samples 0x100..0x107, then 8 DATA reads -> words 0x8000_0100, 0x8100_0101, 0x8200_0102, 0x8300_0103, 0x8000_0104 …; a 9th read returns 0.
- DEC_EN=1, DEC_M=2; push 24 samples (6 frames) -> only frames 0 and 3 are stored; COUNT=8.
- `DEPTH`=64; push 66 samples with no reads -> COUNT=64, FULL=1, OVF=1, `irq`=1. Write 0x0004_0000 to STATUS -> OVF=0. Push and pop in the same cycle -> COUNT stays 64.
- THRESH=3; push 3 samples -> `irq` rises the cycle after the 3rd push; one DATA read -> `irq` falls the next cycle.
- Assert `rst` mid-burst with COUNT=5 -> COUNT=0 and CTRL=0 immediately; `pushADC` after release is ignored until EN is set.
